// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding, counter width, data width.
package dmem_arb_pkg;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] HOST_WAIT = 1'b1;

    localparam int FORCE_CNT_WID = 16;

    // Each residue domain contributes one byte to the data word.
    function automatic int data_wid(input int num_domains);
        return num_domains * 8;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WID = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inc,
    input  logic           clr,
    output logic [WID-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {WID{1'b1}})) begin
            count <= count + WID'(1);
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data memory between the pipeline (priority) and a host port; a host request
// blocked for MAX_WAIT busy cycles takes one memory cycle and stalls the pipeline for it.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_DOMAINS   = 1,
    parameter int DMEM_ADDR_WID = 8,
    parameter int MAX_WAIT      = 4,
    localparam int DW           = data_wid(NUM_DOMAINS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pl_rd_en,
    input  logic                     pl_wr_en,
    input  logic [DMEM_ADDR_WID-1:0] pl_addr,
    input  logic [DW-1:0]            pl_wdata,
    output logic                     pl_stall,
    output logic [DW-1:0]            pl_rdata,
    input  logic                     host_req_valid,
    input  logic                     host_req_we,
    input  logic [DMEM_ADDR_WID-1:0] host_addr,
    input  logic [DW-1:0]            host_wdata,
    output logic                     host_req_ready,
    output logic                     host_rsp_valid,
    output logic [DW-1:0]            host_rsp_data,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [DMEM_ADDR_WID-1:0] mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_dout,
    output logic [FORCE_CNT_WID-1:0] force_count
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [0:0] state;
    logic [3:0] wait_cnt;
    logic       pl_busy;
    logic       force_grant;
    logic       host_grant;

    always_comb begin
        pl_busy     = pl_rd_en | pl_wr_en;
        force_grant = !reset && (state == HOST_WAIT) && (wait_cnt == WAIT_LIMIT) && pl_busy;
        host_grant  = !reset && host_req_valid && (!pl_busy || force_grant);
    end

    // Memory command is a pure mux so the pipeline sees no added latency.
    always_comb begin
        pl_stall       = force_grant;
        host_req_ready = host_grant;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        if (!reset) begin
            mem_en = host_grant | pl_busy;
            if (host_grant) begin
                mem_we    = host_req_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end else begin
                mem_we    = pl_wr_en;
                mem_addr  = pl_addr;
                mem_wdata = pl_wdata;
            end
        end
    end

    assign pl_rdata      = mem_dout;
    assign host_rsp_data = mem_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ARB_IDLE;
            wait_cnt       <= 4'd0;
            host_rsp_valid <= 1'b0;
        end else begin
            host_rsp_valid <= host_grant & !host_req_we;
            if (state == ARB_IDLE) begin
                if (host_req_valid && pl_busy) begin
                    state    <= HOST_WAIT;
                    wait_cnt <= 4'd1;
                end
            end else begin
                // Leaves on any grant (idle pipeline or forced) or if the host withdrew.
                if (!host_req_valid || host_grant) begin
                    state    <= ARB_IDLE;
                    wait_cnt <= 4'd0;
                end else begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end
        end
    end

    sat_counter #(
        .WID(FORCE_CNT_WID)
    ) u_force_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (force_grant),
        .clr  (1'b0),
        .count(force_count)
    );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_port_arbiter;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          pl_rd_en, pl_wr_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_wdata;
    logic          pl_stall;
    logic [DW-1:0] pl_rdata;
    logic          host_req_valid, host_req_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_req_ready, host_rsp_valid;
    logic [DW-1:0] host_rsp_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_dout;
    logic [15:0]   force_count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .NUM_DOMAINS  (1),
        .DMEM_ADDR_WID(AW),
        .MAX_WAIT     (MAXW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pl_rd_en      (pl_rd_en),
        .pl_wr_en      (pl_wr_en),
        .pl_addr       (pl_addr),
        .pl_wdata      (pl_wdata),
        .pl_stall      (pl_stall),
        .pl_rdata      (pl_rdata),
        .host_req_valid(host_req_valid),
        .host_req_we   (host_req_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_req_ready(host_req_ready),
        .host_rsp_valid(host_rsp_valid),
        .host_rsp_data (host_rsp_data),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_dout      (mem_dout),
        .force_count   (force_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Synchronous-read memory macro; contents start as addr ^ 0xB5.
    initial begin : mem_macro
        logic [DW-1:0] tmem [256];
        for (int i = 0; i < 256; i++) tmem[i] = 8'(i) ^ 8'hB5;
        mem_dout = '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) tmem[mem_addr] = mem_wdata;
                else        mem_dout <= tmem[mem_addr];
            end
        end
    end

    // Behavioural model: tracks how many cycles the current host request has been refused.
    initial begin : model
        logic [DW-1:0] shadow [256];
        int            blocked;
        int            fcnt;
        bit            known, rsp_v, pl_pend;
        logic [DW-1:0] rsp_exp, pl_exp;
        bit            busy, frc, g, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hB5;
        blocked = 0; fcnt = 0; known = 0; rsp_v = 0; pl_pend = 0;
        rsp_exp = '0; pl_exp = '0;
        forever begin
            @(negedge clk);
            busy   = pl_rd_en || pl_wr_en;
            frc    = !reset && host_req_valid && busy && (blocked >= MAXW);
            g      = !reset && host_req_valid && (!busy || frc);
            e_en   = !reset && (g || busy);
            e_we   = reset ? 1'b0 : (g ? host_req_we : pl_wr_en);
            e_addr = reset ? '0 : (g ? host_addr : pl_addr);
            e_wd   = reset ? '0 : (g ? host_wdata : pl_wdata);
            chk("m_ready", host_req_ready, g);
            chk("m_stall", pl_stall, frc);
            chk("m_mem_en", mem_en, e_en);
            chk("m_mem_we", mem_we, e_we);
            chk("m_mem_addr", mem_addr, e_addr);
            chk("m_mem_wdata", mem_wdata, e_wd);
            if (known) begin
                chk("m_rsp_valid", host_rsp_valid, rsp_v);
                chk("m_force_count", force_count, fcnt);
                if (rsp_v) chk("m_rsp_data", host_rsp_data, rsp_exp);
            end
            if (pl_pend) chk("m_pl_rdata", pl_rdata, pl_exp);
            if (reset) begin
                blocked = 0; fcnt = 0; rsp_v = 0; pl_pend = 0; known = 1;
            end else begin
                rsp_v   = g && !host_req_we;
                rsp_exp = shadow[host_addr];
                pl_pend = busy && !pl_wr_en && !frc;
                pl_exp  = shadow[pl_addr];
                if (e_en && e_we) shadow[e_addr] = e_wd;
                if (frc && fcnt < 65535) fcnt++;
                if (host_req_valid && !g) blocked++;
                else blocked = 0;
            end
        end
    end

    initial begin : stim
        int  stalls;
        int  r;
        bit  granted, stalled;
        reset = 1'b1;
        pl_rd_en = 1'b1; pl_wr_en = 1'b0; pl_addr = '0; pl_wdata = '0;
        host_req_valid = 1'b0; host_req_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rsp_valid", host_rsp_valid, 0);
        chk("rst_force_count", force_count, 0);
        reset = 1'b0; pl_rd_en = 1'b0;

        // Host read with idle pipeline
        host_req_valid = 1; host_req_we = 0; host_addr = 8'h10;
        #1;
        chk("t1_ready", host_req_ready, 1);
        chk("t1_stall", pl_stall, 0);
        cyc();
        host_req_valid = 0;
        #1;
        chk("t1_rsp_valid", host_rsp_valid, 1);
        chk("t1_rsp_data", host_rsp_data, 8'hA5);

        // Pipeline store wins over concurrent host write
        cyc();
        pl_wr_en = 1; pl_addr = 8'h20; pl_wdata = 8'h3C;
        host_req_valid = 1; host_req_we = 1; host_addr = 8'h21; host_wdata = 8'h77;
        #1;
        chk("t2_ready_blocked", host_req_ready, 0);
        chk("t2_mem_addr_pl", mem_addr, 8'h20);
        cyc();
        pl_wr_en = 0;
        #1;
        chk("t2_ready_idle", host_req_ready, 1);
        chk("t2_mem_wdata_host", mem_wdata, 8'h77);
        cyc();
        host_req_we = 0; host_addr = 8'h20;
        #1;
        cyc();
        host_addr = 8'h21;
        #1;
        chk("t2_read_20", host_rsp_data, 8'h3C);
        cyc();
        host_req_valid = 0;
        #1;
        chk("t2_read_21", host_rsp_data, 8'h77);

        // Forced grant after MAX_WAIT busy cycles
        cyc();
        pl_rd_en = 1; pl_addr = 8'h30;
        host_req_valid = 1; host_req_we = 0; host_addr = 8'h10;
        for (int k = 1; k <= MAXW + 1; k++) begin
            #1;
            chk("t3_ready", host_req_ready, (k == MAXW + 1));
            chk("t3_stall", pl_stall, (k == MAXW + 1));
            if (k <= MAXW) cyc();
        end
        cyc();
        host_req_valid = 0;
        #1;
        chk("t3_force_count", force_count, 1);
        chk("t3_rsp_data", host_rsp_data, 8'hA5);
        chk("t3_replay_addr", mem_addr, 8'h30);
        cyc();
        pl_rd_en = 0;
        #1;
        chk("t3_replay_rdata", pl_rdata, 8'h85);

        // Sustained contention: one stall per MAX_WAIT+1 cycles
        cyc();
        pl_rd_en = 1; pl_addr = 8'h30;
        host_req_valid = 1; host_req_we = 0; host_addr = 8'h10;
        stalls = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (pl_stall) stalls++;
            cyc();
        end
        pl_rd_en = 0; host_req_valid = 0;
        #1;
        chk("t4_stalls", stalls, 10);
        chk("t4_force_count", force_count, 11);

        // Reset right after a granted host read
        cyc();
        host_req_valid = 1; host_req_we = 0; host_addr = 8'h10;
        #1;
        chk("t5_ready", host_req_ready, 1);
        cyc();
        reset = 1; pl_rd_en = 1;
        #1;
        chk("t5_mem_en_rst", mem_en, 0);
        chk("t5_ready_rst", host_req_ready, 0);
        cyc();
        chk("t5_rsp_dropped", host_rsp_valid, 0);
        chk("t5_force_cleared", force_count, 0);
        reset = 0;
        #1;
        chk("t5_idle_no_force", pl_stall, 0);
        cyc();
        pl_rd_en = 0;
        #1;
        chk("t5_grant_after", host_req_ready, 1);
        cyc();
        host_req_valid = 0;

        // Read and write enables together behave as a write
        pl_rd_en = 1; pl_wr_en = 1; pl_addr = 8'h05; pl_wdata = 8'h99;
        #1;
        chk("t6_mem_we", mem_we, 1);
        cyc();
        pl_rd_en = 0; pl_wr_en = 0;
        host_req_valid = 1; host_req_we = 0; host_addr = 8'h05;
        #1;
        cyc();
        host_req_valid = 0;
        #1;
        chk("t6_readback", host_rsp_data, 8'h99);

        // Randomized traffic, host obeys the valid/ready hold rule
        granted = 0; stalled = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (!stalled) begin
                r = $urandom_range(0, 9);
                pl_rd_en = (r < 4) || (r == 9);
                pl_wr_en = (r >= 4 && r < 7) || (r == 9);
                pl_addr  = 8'($urandom_range(0, 15));
                pl_wdata = 8'($urandom);
            end
            if (!host_req_valid || granted) begin
                host_req_valid = 1'($urandom_range(0, 1));
                host_req_we    = 1'($urandom_range(0, 1));
                host_addr      = 8'($urandom_range(0, 15));
                host_wdata     = 8'($urandom);
            end
            #1;
            granted = host_req_ready;
            stalled = pl_stall;
        end
        cyc();
        pl_rd_en = 0; pl_wr_en = 0; host_req_valid = 0;
        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM/WB stage and a host/loader requester. The pipeline has priority. A host request waiting more than MAX_WAIT busy cycles wins one memory cycle, and the arbiter stalls the pipeline for that cycle. The block sits between the MEM/WB stage, the host load/debug port and the data memory macro (synchronous read, 1-cycle latency).

Parameters:
NUM_DOMAINS, 1, number of 8-bit residue domains; data width is NUM_DOMAINS*8
DMEM_ADDR_WID, 8, data memory address width
MAX_WAIT, 4, host wait cycles before a forced grant; legal range 1..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pl_rd_en  in  1  pipeline load access this cycle
pl_wr_en  in  1  pipeline store; already gated by invalidate upstream
pl_addr  in  DMEM_ADDR_WID  pipeline address
pl_wdata  in  NUM_DOMAINS*8  pipeline store data
pl_stall  out  1  pipeline must hold MEM/WB contents this cycle
pl_rdata  out  NUM_DOMAINS*8  pass-through of mem_dout
host_req_valid  in  1  host request pending
host_req_we  in  1  1 = write, 0 = read
host_addr  in  DMEM_ADDR_WID  host address
host_wdata  in  NUM_DOMAINS*8  host write data
host_req_ready  out  1  host request accepted this cycle
host_rsp_valid  out  1  host read data valid
host_rsp_data  out  NUM_DOMAINS*8  host read data
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  DMEM_ADDR_WID  memory address
mem_wdata  out  NUM_DOMAINS*8  memory write data
mem_dout  in  NUM_DOMAINS*8  memory read data, valid 1 cycle after a read
force_count  out  16  saturating count of forced (stall) grants

Behaviour:
- Reset values: state=ARB_IDLE, wait_cnt=0, host_rsp_valid=0, force_count=0.
- Combinational outputs (pl_stall, host_req_ready, mem_*) are 0 while reset=1.
- pl_busy = pl_rd_en | pl_wr_en. If pl_rd_en and pl_wr_en are both set, the access is a write.
- host_grant (combinational) = host_req_valid & (!pl_busy | force).
- force = (state==HOST_WAIT) & (wait_cnt==MAX_WAIT) & pl_busy.
- pl_stall = force. The pipeline access is dropped that cycle, and the pipeline re-presents it the next cycle.
- host_req_ready = host_grant. On a grant, mem_* carry the host command; otherwise they carry the pipeline command.
- mem_en = host_grant | pl_busy.
- The memory command is a combinational mux, so pipeline timing is unchanged: 0 added latency.
- Host handshake: host_req_valid and all host fields must stay stable until host_req_ready. One transfer per ready cycle, so back-to-back host grants are legal when the pipeline is idle.
- Host read response: host_rsp_valid is registered, set the cycle after a granted host read and cleared otherwise. host_rsp_data = mem_dout (pass-through) in that cycle. There is no backpressure on responses.
- FSM:
  - ARB_IDLE:
    - host_req_valid & !pl_busy -> grant, stay ARB_IDLE.
    - host_req_valid & pl_busy -> HOST_WAIT, wait_cnt=1.
  - HOST_WAIT:
    - !host_req_valid (protocol violation) -> ARB_IDLE, wait_cnt=0.
    - !pl_busy -> grant -> ARB_IDLE, wait_cnt=0.
    - force -> grant, pl_stall -> ARB_IDLE, wait_cnt=0, force_count+1 (saturates at 0xFFFF).
    - otherwise wait_cnt+1.
- Fairness: after a forced grant, the next force requires at least MAX_WAIT further busy cycles, so pipeline stall duty is at most 1/(MAX_WAIT+1).
- wait_cnt width = 4 bits. It never exceeds MAX_WAIT.
- Reset mid-operation: an in-flight host read response is dropped (host_rsp_valid=0 next cycle), and the FSM returns to ARB_IDLE.
- A pipeline read and a host read in consecutive cycles are legal. pl_rdata and host_rsp_data both mirror mem_dout; each consumer qualifies by its own timing.

Decomposition:
- Shared package dmem_arb_pkg: FSM state encoding (ARB_IDLE=1'b0, HOST_WAIT=1'b1), FORCE_CNT_WID=16, and the data-width function NUM_DOMAINS*8.
- One natural sub-module: sat_counter (parameterised width, inc/clr, saturates), used for force_count.
- FSM and mux stay in the top module.

Test Plan:
- Host read to addr 0x10 (mem holds 0xA5), pipeline idle -> host_req_ready in cycle 0; host_rsp_valid=1 with data 0xA5 in cycle 1; pl_stall never asserted.
- Pipeline store 0x3C@0x20 concurrent with host write 0x77@0x21 -> pipeline wins, host_req_ready=0; host granted the first idle pipeline cycle; readback gives 0x3C and 0x77.
- MAX_WAIT=4, pipeline busy every cycle, host read pending -> ready and pl_stall both high in exactly the 5th cycle; force_count=1; the pipeline access is repeated the next cycle and lands correctly.
- Continuous busy pipeline plus continuous host requests for 50 cycles -> stalls are exactly 1 in every 5 cycles (10 stalls); force_count=10.
- Host read granted, reset asserted the next cycle -> host_rsp_valid=0, state ARB_IDLE, force_count=0, mem_en=0 during reset.
- pl_rd_en and pl_wr_en both high with data 0x99@0x05 -> mem_we=1; memory at 0x05 = 0x99.
